// File: rtl/rf_readcache.sv
// Multi-port read cache in front of a single-read-port register array.
// Each port keeps one tagged line. Misses are refilled one per cycle under round-robin arbitration.
module rf_readcache #(
    parameter int DW      = 64,
    parameter int AW      = 8,
    parameter int NPORTS  = 4,
    parameter int FORWARD = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NPORTS-1:0]    rd_req,
    input  logic [NPORTS*AW-1:0] rd_addr,
    output logic [NPORTS-1:0]    rd_valid,
    output logic [NPORTS*DW-1:0] rd_data,
    input  logic                 we,
    input  logic [AW-1:0]        wa,
    input  logic [DW-1:0]        wd,
    output logic                 fill_busy
);

    localparam int PW    = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int DEPTH = 1 << AW;
    localparam logic [PW:0]   NP_EXT    = (PW+1)'(NPORTS);
    localparam logic [PW-1:0] LAST_PORT = PW'(NPORTS - 1);

    logic [DW-1:0]     mem [DEPTH];
    logic [AW-1:0]     tag_reg [NPORTS];
    logic [DW-1:0]     line_reg [NPORTS];
    logic [NPORTS-1:0] tv_reg;
    logic [PW-1:0]     rr_ptr_reg;

    logic [AW-1:0]     addr [NPORTS];
    logic [NPORTS-1:0] hit;
    logic [NPORTS-1:0] miss;
    logic [NPORTS-1:0] fill_load;

    logic              grant_valid;
    logic [PW-1:0]     grant_idx;
    logic [PW:0]       scan_idx;
    logic [AW-1:0]     fill_addr;
    logic [DW-1:0]     fill_data;

    genvar gi;
    generate
        for (gi = 0; gi < NPORTS; gi++) begin : g_port
            assign addr[gi]              = rd_addr[gi*AW +: AW];
            assign hit[gi]               = tv_reg[gi] && (tag_reg[gi] == addr[gi]);
            assign miss[gi]              = rd_req[gi] && !hit[gi];
            assign rd_valid[gi]          = !rd_req[gi] || hit[gi];
            assign rd_data[gi*DW +: DW]  = line_reg[gi];
            // Every requester of the granted address shares the same refill.
            assign fill_load[gi]         = grant_valid && rd_req[gi] && (addr[gi] == fill_addr);
        end
    endgenerate

    // Round-robin scan starting at rr_ptr_reg, wrapping at NPORTS (need not be a power of two).
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NPORTS; k++) begin
            scan_idx = {1'b0, rr_ptr_reg} + (PW+1)'(k);
            if (scan_idx >= NP_EXT) begin
                scan_idx = scan_idx - NP_EXT;
            end
            if (!grant_valid && miss[scan_idx[PW-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = scan_idx[PW-1:0];
            end
        end
    end

    assign fill_addr = addr[grant_idx];
    // Write-first bypass so a refill racing a write to the same address sees the new data.
    assign fill_data = (we && (wa == fill_addr)) ? wd : mem[fill_addr];
    assign fill_busy = grant_valid;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
        if (reset) begin
            tv_reg     <= '0;
            rr_ptr_reg <= '0;
            for (int k = 0; k < NPORTS; k++) begin
                tag_reg[k]  <= '0;
                line_reg[k] <= '0;
            end
        end else begin
            if (grant_valid) begin
                rr_ptr_reg <= (grant_idx == LAST_PORT) ? '0 : grant_idx + 1'b1;
            end
            for (int k = 0; k < NPORTS; k++) begin
                if (fill_load[k]) begin
                    tag_reg[k]  <= fill_addr;
                    line_reg[k] <= fill_data;
                    tv_reg[k]   <= 1'b1;
                end else if (we && tv_reg[k] && (tag_reg[k] == wa)) begin
                    if (FORWARD != 0) begin
                        line_reg[k] <= wd;
                    end else begin
                        tv_reg[k] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_readcache.sv
// Bench for rf_readcache: a forwarding and an invalidating instance share one stimulus stream.
// Both are checked every cycle against a behavioural cache model, plus directed literal checks.
module tb_rf_readcache;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NP    = 6;
    localparam int DEPTH = 1 << AW;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NP-1:0]     rd_req = '0;
    logic [NP*AW-1:0]  rd_addr = '0;
    logic              we = 1'b0;
    logic [AW-1:0]     wa = '0;
    logic [DW-1:0]     wd = '0;

    logic [NP-1:0]     valid_o [2];
    logic [NP*DW-1:0]  data_o [2];
    logic              busy_o [2];

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    rf_readcache #(.DW(DW), .AW(AW), .NPORTS(NP), .FORWARD(1)) dut_fwd (
        .clk(clk), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_valid(valid_o[0]), .rd_data(data_o[0]),
        .we(we), .wa(wa), .wd(wd), .fill_busy(busy_o[0])
    );

    rf_readcache #(.DW(DW), .AW(AW), .NPORTS(NP), .FORWARD(0)) dut_inv (
        .clk(clk), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_valid(valid_o[1]), .rd_data(data_o[1]),
        .we(we), .wa(wa), .wd(wd), .fill_busy(busy_o[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: index 0 = forwarding cache, index 1 = invalidating cache.
    bit            m_tv   [2][NP];
    logic [AW-1:0] m_tag  [2][NP];
    logic [DW-1:0] m_line [2][NP];
    int            m_rr   [2];
    logic [DW-1:0] m_mem  [DEPTH];

    function automatic logic [AW-1:0] port_addr(input int p);
        return rd_addr[p*AW +: AW];
    endfunction

    function automatic bit m_hit(input int f, input int p);
        return m_tv[f][p] && (m_tag[f][p] == port_addr(p));
    endfunction

    task automatic model_compare();
        logic [NP-1:0] ev;
        logic          eb;
        for (int f = 0; f < 2; f++) begin
            ev = '0;
            eb = 1'b0;
            for (int p = 0; p < NP; p++) begin
                ev[p] = !rd_req[p] || m_hit(f, p);
                if (rd_req[p] && !m_hit(f, p)) eb = 1'b1;
                check($sformatf("model data dut%0d port%0d", f, p), 64'(data_o[f][p*DW +: DW]), 64'(m_line[f][p]));
            end
            check($sformatf("model valid dut%0d", f), 64'(valid_o[f]), 64'(ev));
            check($sformatf("model busy dut%0d", f), 64'(busy_o[f]), 64'(eb));
        end
    endtask

    task automatic model_step();
        int            g;
        int            p;
        logic [AW-1:0] ga;
        logic [DW-1:0] fd;
        bit            loaded;
        for (int f = 0; f < 2; f++) begin
            if (reset) begin
                m_rr[f] = 0;
                for (int q = 0; q < NP; q++) begin
                    m_tv[f][q] = 1'b0;
                    m_tag[f][q] = '0;
                    m_line[f][q] = '0;
                end
            end else begin
                g = -1;
                for (int k = 0; k < NP; k++) begin
                    p = (m_rr[f] + k) % NP;
                    if (g < 0 && rd_req[p] && !m_hit(f, p)) g = p;
                end
                ga = (g >= 0) ? port_addr(g) : '0;
                fd = (we && wa == ga) ? wd : m_mem[ga];
                for (int q = 0; q < NP; q++) begin
                    loaded = (g >= 0) && rd_req[q] && (port_addr(q) == ga);
                    if (loaded) begin
                        m_tv[f][q] = 1'b1;
                        m_tag[f][q] = ga;
                        m_line[f][q] = fd;
                    end else if (we && m_tv[f][q] && m_tag[f][q] == wa) begin
                        if (f == 0) m_line[f][q] = wd;
                        else m_tv[f][q] = 1'b0;
                    end
                end
                if (g >= 0) m_rr[f] = (g + 1) % NP;
            end
        end
        if (we) m_mem[wa] = wd;
    endtask

    // Inputs change just after posedge, so at negedge they are what the next edge will sample.
    always @(negedge clk) begin
        if (chk_en) model_compare();
        model_step();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rd_req = '0;
        we = 1'b0;
        tick();
        reset = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic mem_write(input int a, input logic [DW-1:0] d);
        we = 1'b1;
        wa = AW'(a);
        wd = d;
        tick();
        we = 1'b0;
    endtask

    task automatic set_req(input int p, input int a);
        rd_req[p] = 1'b1;
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    function automatic logic [DW-1:0] port_data(input int f, input int p);
        return data_o[f][p*DW +: DW];
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, vectors %0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        @(negedge clk);
        check("reset valid", 64'(valid_o[0]), 64'h3F);
        check("reset data zero", 64'(data_o[0] == '0), 64'd1);
        check("reset busy", 64'(busy_o[0]), 64'd0);
        for (int a = 0; a < DEPTH; a++) mem_write(a, $urandom);

        // Lone miss: invalid for one cycle, then data.
        mem_write(5, 32'hA5);
        set_req(0, 5);
        @(negedge clk);
        check("t1 miss valid", 64'(valid_o[0][0]), 64'd0);
        tick();
        @(negedge clk);
        check("t1 hit valid", 64'(valid_o[0][0]), 64'd1);
        check("t1 data fwd", 64'(port_data(0, 0)), 64'hA5);
        check("t1 data inv", 64'(port_data(1, 0)), 64'hA5);
        tick();

        // Four distinct misses from rr=0, then from rr=2.
        do_reset();
        for (int a = 1; a <= 4; a++) mem_write(a, 32'h10 + a);
        for (int p = 0; p < 4; p++) set_req(p, p + 1);
        begin
            logic [5:0] exp_a [5];
            logic [5:0] exp_b [5];
            exp_a = '{6'b110000, 6'b110001, 6'b110011, 6'b110111, 6'b111111};
            exp_b = '{6'b110000, 6'b110100, 6'b111100, 6'b111101, 6'b111111};
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                check($sformatf("t2 rr0 valid cycle%0d", c), 64'(valid_o[0]), 64'(exp_a[c]));
                tick();
            end
            rd_req = '0;
            set_req(1, 10);
            @(negedge clk);
            check("t2 port1 miss", 64'(valid_o[0]), 64'b111101);
            tick();
            for (int p = 0; p < 4; p++) set_req(p, p + 11);
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                check($sformatf("t2 rr2 valid cycle%0d", c), 64'(valid_o[0]), 64'(exp_b[c]));
                tick();
            end
        end

        // Two ports on one address share a single refill.
        do_reset();
        mem_write(7, 32'h77);
        set_req(0, 7);
        set_req(3, 7);
        @(negedge clk);
        check("t3 miss valid", 64'(valid_o[0]), 64'b110110);
        check("t3 busy", 64'(busy_o[0]), 64'd1);
        tick();
        @(negedge clk);
        check("t3 valid", 64'(valid_o[0]), 64'h3F);
        check("t3 busy idle", 64'(busy_o[0]), 64'd0);
        check("t3 data p0", 64'(port_data(0, 0)), 64'h77);
        check("t3 data p3", 64'(port_data(0, 3)), 64'h77);
        tick();

        // Write to a hit line: forward vs invalidate.
        do_reset();
        mem_write(9, 32'h11);
        set_req(1, 9);
        @(negedge clk);
        tick();
        we = 1'b1; wa = 5'd9; wd = 32'h22;
        @(negedge clk);
        check("t4 hit data", 64'(port_data(0, 1)), 64'h11);
        check("t4 hit valid inv", 64'(valid_o[1][1]), 64'd1);
        tick();
        we = 1'b0;
        @(negedge clk);
        check("t4 fwd valid", 64'(valid_o[0][1]), 64'd1);
        check("t4 fwd data", 64'(port_data(0, 1)), 64'h22);
        check("t4 inv valid", 64'(valid_o[1][1]), 64'd0);
        check("t4 inv busy", 64'(busy_o[1]), 64'd1);
        tick();
        @(negedge clk);
        check("t4 inv refill valid", 64'(valid_o[1][1]), 64'd1);
        check("t4 inv refill data", 64'(port_data(1, 1)), 64'h22);
        tick();

        // Refill racing a write to the same address.
        do_reset();
        set_req(0, 3);
        we = 1'b1; wa = 5'd3; wd = 32'hBEEF;
        @(negedge clk);
        check("t5 miss valid", 64'(valid_o[0][0]), 64'd0);
        tick();
        we = 1'b0;
        @(negedge clk);
        check("t5 valid", 64'(valid_o[0][0]), 64'd1);
        check("t5 data fwd", 64'(port_data(0, 0)), 64'hBEEF);
        check("t5 data inv", 64'(port_data(1, 0)), 64'hBEEF);
        tick();

        // Reset in the middle of a miss burst.
        do_reset();
        for (int a = 1; a <= 4; a++) mem_write(a, 32'h40 + a);
        for (int p = 0; p < 4; p++) set_req(p, p + 1);
        @(negedge clk);
        check("t6 burst start", 64'(valid_o[0]), 64'b110000);
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("t6 first fill", 64'(valid_o[0]), 64'b110001);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("t6 after reset valid", 64'(valid_o[0]), 64'b110000);
        check("t6 after reset data zero", 64'(data_o[0] == '0), 64'd1);
        tick();
        @(negedge clk);
        check("t6 restart port0", 64'(valid_o[0]), 64'b110001);
        tick();

        // Random traffic on a small address window to provoke sharing and write collisions.
        do_reset();
        for (int c = 0; c < 8000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            we = !reset && ($urandom_range(0, 9) < 3);
            wa = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(0, DEPTH - 1)) : AW'($urandom_range(0, 7));
            wd = $urandom;
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 3) == 0) rd_addr[p*AW +: AW] = AW'($urandom_range(0, 9));
                rd_req[p] = ($urandom_range(0, 9) < 7);
            end
            tick();
        end
        reset = 1'b0;
        we = 1'b0;
        rd_req = '0;
        tick();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
